// File: rtl/fft_out_serializer.sv
// Converts a parallel FFT frame in bit-reversed order into a natural-order sample stream.
// A one-frame buffer is reloaded on the last-sample handshake, so back-to-back frames stream without gaps.
module fft_out_serializer #(
    parameter int unsigned N            = 4,
    parameter int unsigned SAMPLE_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             arst_n,
    input  logic [N-1:0][SAMPLE_WIDTH-1:0]   frame_in,
    input  logic                             frame_valid_in,
    output logic                             frame_ready_out,
    output logic [SAMPLE_WIDTH-1:0]          sample_out,
    output logic                             sample_valid_out,
    input  logic                             sample_ready_in,
    output logic [$clog2(N)-1:0]             sample_index_out,
    output logic                             sample_last_out
);

    localparam int unsigned IdxW = $clog2(N);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    function automatic int unsigned bit_rev(input int unsigned k);
        int unsigned r;
        r = 0;
        for (int b = 0; b < int'(IdxW); b++) begin
            r = r | (((k >> b) & 1) << (int'(IdxW) - 1 - b));
        end
        return r;
    endfunction

    logic [0:0]                          state_q, state_d;
    logic [IdxW-1:0]                     idx_q, idx_d;
    logic [N-1:0][SAMPLE_WIDTH-1:0]      buf_q;
    logic [N-1:0][SAMPLE_WIDTH-1:0]      frame_nat;
    logic                                streaming;
    logic                                is_last;
    logic                                sample_hs;
    logic                                frame_hs;

    // Reorder the incoming frame so buffer slot k holds natural bin k.
    for (genvar k = 0; k < N; k++) begin : g_reorder
        localparam int unsigned Rev = bit_rev(k);
        assign frame_nat[k] = frame_in[Rev];
    end

    assign streaming = (state_q == STREAM);
    assign is_last   = streaming && (idx_q == LastIdx);
    assign sample_hs = streaming && sample_ready_in;
    assign frame_ready_out = !streaming || (sample_hs && is_last);
    assign frame_hs  = frame_valid_in && frame_ready_out;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (frame_hs) begin
            state_d = STREAM;
            idx_d   = '0;
        end else if (sample_hs) begin
            if (is_last) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IdxW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (frame_hs) begin
                buf_q <= frame_nat;
            end
        end
    end

    assign sample_valid_out = streaming;
    assign sample_out       = streaming ? buf_q[idx_q] : '0;
    assign sample_index_out = idx_q;
    assign sample_last_out  = is_last;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Directed bench for fft_out_serializer (N=4): ordering, backpressure, back-to-back, blocking,
// mid-stream reset and an end-to-end check against an integer 4-point DFT.
module tb_fft_out_serializer;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 16;

    logic                  clk;
    logic                  arst_n;
    logic [N-1:0][SW-1:0]  frame_in;
    logic                  frame_valid_in;
    logic                  frame_ready_out;
    logic [SW-1:0]         sample_out;
    logic                  sample_valid_out;
    logic                  sample_ready_in;
    logic [1:0]            sample_index_out;
    logic                  sample_last_out;

    int tests;
    int fails;

    logic [N-1:0][SW-1:0] frame_a;
    logic [N-1:0][SW-1:0] frame_b;
    logic [SW-1:0]        a_order [4];
    logic [SW-1:0]        b_order [4];
    int                   x_vec   [4];
    logic [SW-1:0]        ref_bin [4];

    fft_out_serializer #(
        .N            (N),
        .SAMPLE_WIDTH (SW)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .frame_in         (frame_in),
        .frame_valid_in   (frame_valid_in),
        .frame_ready_out  (frame_ready_out),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .sample_index_out (sample_index_out),
        .sample_last_out  (sample_last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sample(input string tag, input logic [SW-1:0] exp_s, input int exp_i);
        chk({tag, ".valid"}, 32'(sample_valid_out), 32'd1);
        chk({tag, ".data"}, 32'(sample_out), 32'(exp_s));
        chk({tag, ".idx"}, 32'(sample_index_out), 32'(exp_i));
        chk({tag, ".last"}, 32'(sample_last_out), 32'(exp_i == 3));
    endtask

    function automatic int br2(input int k);
        return ((k & 1) << 1) | ((k >> 1) & 1);
    endfunction

    // 4-point DFT with exact twiddles (-j)^m; result packed {imag[7:0], real[7:0]}.
    task automatic compute_ref();
        for (int k = 0; k < 4; k++) begin
            int re, im, m;
            logic [7:0] re8, im8;
            re = 0;
            im = 0;
            for (int n = 0; n < 4; n++) begin
                m = (n * k) % 4;
                case (m)
                    0: re += x_vec[n];
                    1: im -= x_vec[n];
                    2: re -= x_vec[n];
                    default: im += x_vec[n];
                endcase
            end
            re8 = re[7:0];
            im8 = im[7:0];
            ref_bin[k] = {im8, re8};
        end
    endtask

    task automatic run_e2e(input string tag);
        compute_ref();
        for (int j = 0; j < 4; j++) frame_in[j] = ref_bin[br2(j)];
        frame_valid_in  = 1'b1;
        sample_ready_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_sample($sformatf("%s.bin%0d", tag, k), ref_bin[k], k);
            tick();
        end
        chk({tag, ".done"}, 32'(sample_valid_out), 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        frame_a = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
        frame_b = {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A};
        a_order = '{16'h0101, 16'h0303, 16'h0202, 16'h0404};
        b_order = '{16'h0A0A, 16'h0C0C, 16'h0B0B, 16'h0D0D};

        arst_n = 1'b0;
        frame_in = '0;
        frame_valid_in = 1'b0;
        sample_ready_in = 1'b0;
        #1;
        chk("rst.ready", 32'(frame_ready_out), 32'd1);
        chk("rst.valid", 32'(sample_valid_out), 32'd0);
        chk("rst.last", 32'(sample_last_out), 32'd0);
        chk("rst.data", 32'(sample_out), 32'd0);
        chk("rst.idx", 32'(sample_index_out), 32'd0);
        #11;
        arst_n = 1'b1;

        // Single frame, accepted on the first edge after reset release.
        frame_in = frame_a;
        frame_valid_in = 1'b1;
        sample_ready_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_sample($sformatf("single.s%0d", k), a_order[k], k);
            chk($sformatf("single.fready%0d", k), 32'(frame_ready_out), 32'(k == 3));
            tick();
        end
        chk("single.idle_valid", 32'(sample_valid_out), 32'd0);
        chk("single.idle_ready", 32'(frame_ready_out), 32'd1);

        // Backpressure at idx 1.
        frame_valid_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        chk_sample("bp.s0", 16'h0101, 0);
        tick();
        chk_sample("bp.s1", 16'h0303, 1);
        sample_ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_sample($sformatf("bp.hold%0d", c), 16'h0303, 1);
            chk($sformatf("bp.fready%0d", c), 32'(frame_ready_out), 32'd0);
        end
        sample_ready_in = 1'b1;
        tick();
        chk_sample("bp.s2", 16'h0202, 2);
        tick();
        chk_sample("bp.s3", 16'h0404, 3);
        tick();
        chk("bp.done", 32'(sample_valid_out), 32'd0);

        // Back-to-back frames A then B with no bubble.
        frame_in = frame_a;
        frame_valid_in = 1'b1;
        tick();
        frame_in = frame_b;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) chk_sample($sformatf("b2b.a%0d", i), a_order[i], i);
            else       chk_sample($sformatf("b2b.b%0d", i - 4), b_order[i - 4], i - 4);
            chk($sformatf("b2b.fready%0d", i), 32'(frame_ready_out), 32'(i == 3 || i == 7));
            if (i == 4) frame_valid_in = 1'b0;
            tick();
        end
        chk("b2b.done", 32'(sample_valid_out), 32'd0);

        // Frame B offered while A sits at idx 0 under backpressure.
        frame_in = frame_a;
        frame_valid_in = 1'b1;
        tick();
        frame_in = frame_b;
        sample_ready_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk_sample($sformatf("blk.hold%0d", c), 16'h0101, 0);
            chk($sformatf("blk.fready_h%0d", c), 32'(frame_ready_out), 32'd0);
            tick();
        end
        sample_ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk_sample($sformatf("blk.a%0d", k), a_order[k], k);
            chk($sformatf("blk.fready%0d", k), 32'(frame_ready_out), 32'(k == 3));
            tick();
        end
        frame_valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_sample($sformatf("blk.b%0d", k), b_order[k], k);
            tick();
        end
        chk("blk.done", 32'(sample_valid_out), 32'd0);

        // Reset pulse at idx 2 discards the frame.
        frame_in = frame_a;
        frame_valid_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        tick();
        tick();
        chk_sample("mrst.pre", 16'h0202, 2);
        #2;
        arst_n = 1'b0;
        #1;
        chk("mrst.valid", 32'(sample_valid_out), 32'd0);
        chk("mrst.idx", 32'(sample_index_out), 32'd0);
        chk("mrst.data", 32'(sample_out), 32'd0);
        chk("mrst.ready", 32'(frame_ready_out), 32'd1);
        #3;
        arst_n = 1'b1;
        tick();
        chk("mrst.no_remnant", 32'(sample_valid_out), 32'd0);
        frame_in = frame_b;
        frame_valid_in = 1'b1;
        tick();
        frame_valid_in = 1'b0;
        chk_sample("mrst.b0", 16'h0A0A, 0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_sample($sformatf("mrst.b%0d", k), b_order[k], k);
        end
        tick();

        // End-to-end: DFT result in bit-reversed order back to natural order.
        x_vec = '{1, 2, 3, 4};
        run_e2e("e2e1");
        x_vec = '{5, -3, 7, 0};
        run_e2e("e2e2");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
